// File: rtl/dna_reader_p2_if.sv
// dna_reader_p2 bus: read request, DNA primitive control/data and result.
// Instance parameter ID_W must match the reader it connects to.
interface dna_reader_p2_if #(
  parameter int ID_W = 57,
  parameter int CW   = $clog2(ID_W + 1)
) ();
  logic              START;
  logic [ID_W-1:0]   EXPECT;
  logic              DNA_DOUT;
  logic              DNA_READ;
  logic              DNA_SHIFT;
  logic              DNA_CLK;
  logic [ID_W+CW:0]  DNA_CODE;
  logic              VALID;
  logic              BUSY;
  logic              MATCH;

  modport master (
    output START, EXPECT, DNA_DOUT,
    input  DNA_READ, DNA_SHIFT, DNA_CLK,
    input  DNA_CODE, VALID, BUSY, MATCH
  );

  modport slave (
    input  START, EXPECT, DNA_DOUT,
    output DNA_READ, DNA_SHIFT, DNA_CLK,
    output DNA_CODE, VALID, BUSY, MATCH
  );
endinterface

// File: rtl/dna_reader_p2.sv
// Device-DNA serial reader: ID, popcount and parity in one code word.
// Define DNA_MATCH_EN to enable the EXPECT comparator driving MATCH.
module dna_reader_p2 #(
  parameter int ID_W       = 57,
  parameter int DIV        = 1,
  parameter int AUTO_START = 1
) (
  input  logic CLK4,
  input  logic RST,
  dna_reader_p2_if.slave bus
);
  localparam int CW = $clog2(ID_W + 1);

  typedef enum logic [3:0] {
    IDLE, LD_RD, LD_CKH, LD_CKL, ARM,
    SAMPLE, SH_CKH, SH_CKL, FINAL, DONE
  } state_t;

  // control word {busy, read, shift, clk}
  localparam logic [3:0] C_OFF  = 4'b0000;
  localparam logic [3:0] C_RD   = 4'b1100;
  localparam logic [3:0] C_RDCK = 4'b1101;
  localparam logic [3:0] C_SH   = 4'b1010;
  localparam logic [3:0] C_SHCK = 4'b1011;
  localparam logic [3:0] C_FIN  = 4'b1000;

  localparam logic [7:0]    DIVM1 = 8'(DIV - 1);
  localparam logic [CW-1:0] LAST  = CW'(ID_W - 1);

  state_t            r_state;
  logic [3:0]        r_ctl;
  logic [7:0]        r_div;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_pop;
  logic [ID_W-1:0]   r_raw;
  logic [ID_W+CW:0]  r_code;
  logic              r_valid;
  logic              r_match;
  logic              r_auto;
  logic              w_eq;

`ifdef DNA_MATCH_EN
  assign w_eq = (r_raw == bus.EXPECT);
`else
  assign w_eq = 1'b0;
`endif

  always_ff @(posedge CLK4) begin
    if (RST) begin
      r_state <= IDLE;
      r_ctl   <= C_OFF;
      r_div   <= '0;
      r_cnt   <= '0;
      r_pop   <= '0;
      r_raw   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
      r_auto  <= (AUTO_START != 0);
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.START || r_auto) begin
            r_state <= LD_RD;
            r_ctl   <= C_RD;
            r_auto  <= 1'b0;
            r_cnt   <= '0;
            r_pop   <= '0;
          end
        end
        LD_RD: begin
          r_state <= LD_CKH;
          r_ctl   <= C_RDCK;
          r_div   <= DIVM1;
        end
        LD_CKH: begin
          if (r_div == 8'd0) begin
            r_state <= LD_CKL;
            r_ctl   <= C_RD;
            r_div   <= DIVM1;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        LD_CKL: begin
          if (r_div == 8'd0) begin
            r_state <= ARM;
            r_ctl   <= C_SH;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        ARM: begin
          r_state <= SAMPLE;
          r_ctl   <= C_SH;
        end
        SAMPLE: begin
          // first bit read drifts down to the raw LSB
          r_raw <= {bus.DNA_DOUT, r_raw[ID_W-1:1]};
          r_pop <= r_pop + CW'(bus.DNA_DOUT);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt != LAST) begin
            r_state <= SH_CKH;
            r_ctl   <= C_SHCK;
            r_div   <= DIVM1;
          end else begin
            r_state <= FINAL;
            r_ctl   <= C_FIN;
          end
        end
        SH_CKH: begin
          if (r_div == 8'd0) begin
            r_state <= SH_CKL;
            r_ctl   <= C_SH;
            r_div   <= DIVM1;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        SH_CKL: begin
          if (r_div == 8'd0) begin
            r_state <= SAMPLE;
            r_ctl   <= C_SH;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        FINAL: begin
          r_code  <= {r_raw, r_pop, ^{r_raw, r_pop}};
          r_valid <= 1'b1;
          r_match <= w_eq;
          r_state <= DONE;
          r_ctl   <= C_OFF;
        end
        DONE: begin
          if (bus.START) begin
            r_state <= LD_RD;
            r_ctl   <= C_RD;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_pop   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ctl   <= C_OFF;
          r_code  <= '0;
          r_valid <= 1'b0;
          r_match <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY      = r_ctl[3];
  assign bus.DNA_READ  = r_ctl[2];
  assign bus.DNA_SHIFT = r_ctl[1];
  assign bus.DNA_CLK   = r_ctl[0];
  assign bus.DNA_CODE  = r_code;
  assign bus.VALID     = r_valid;
  assign bus.MATCH     = r_match;
endmodule
